// File: rtl/rv32im_wb_arbiter_pkg.sv
// Shared rv32im definitions for the writeback arbiter slice.
//   REG_ADDR_W - register address width
//   XLEN       - data path width
//   NUM_REGS   - architectural register count
//   wb_state_e - anti-starvation FSM states (PRI0 = p0 priority, FORCE1 = p1 forced)
package rv32im_wb_arbiter_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned XLEN       = 32;
    localparam int unsigned NUM_REGS   = 32;

    typedef enum logic {
        PRI0   = 1'b0,
        FORCE1 = 1'b1
    } wb_state_e;

endpackage

// File: rtl/rv32im_wb_scoreboard.sv
// Busy scoreboard for outstanding MUL/DIV destination registers.
//   clk, rst_n           - clock, asynchronous active-low reset
//   set_en, set_rd       - mark a register busy (issue of a MUL/DIV op)
//   clr_en, clr_rd       - mark a register free (p1 writeback transfer)
//   rs1_addr, rs2_addr   - lookup addresses
//   rs1_busy, rs2_busy   - combinational lookup results (current state, no bypass)
// Register 0 never reports busy.
module rv32im_wb_scoreboard
    import rv32im_wb_arbiter_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  set_en,
    input  logic [REG_ADDR_W-1:0] set_rd,
    input  logic                  clr_en,
    input  logic [REG_ADDR_W-1:0] clr_rd,
    input  logic [REG_ADDR_W-1:0] rs1_addr,
    input  logic [REG_ADDR_W-1:0] rs2_addr,
    output logic                  rs1_busy,
    output logic                  rs2_busy
);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;

    // Clear is applied before set so a coincident set on the same register wins.
    always_comb begin
        busy_d = busy_q;
        if (clr_en) busy_d[clr_rd] = 1'b0;
        if (set_en) busy_d[set_rd] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy_q <= '0;
        else        busy_q <= busy_d;
    end

    assign rs1_busy = busy_q[rs1_addr];
    assign rs2_busy = busy_q[rs2_addr];

endmodule

// File: rtl/rv32im_wb_arbiter.sv
// Register-file writeback arbiter between the in-order pipeline (p0) and the
// multi-cycle MUL/DIV unit (p1), with a busy scoreboard for MUL/DIV results.
//   clk_i, rst_n_i                     - clock, asynchronous active-low reset
//   p0_valid_i/p0_ready_o, p0_rd_i, p0_data_i - pipeline writeback request
//   p1_valid_i/p1_ready_o, p1_rd_i, p1_data_i - MUL/DIV writeback request
//   issue_valid_i, issue_rd_i          - MUL/DIV issue, marks rd busy
//   rs1/rs2_addr_i, rs1/rs2_busy_o     - scoreboard lookups
//   we_o, rd_addr_o, val_rd_o          - registered register-file write port
// Macro RV32IM_WB_STARVE_EN: when defined, p1 is force-granted after losing
// STARVE_LIMIT consecutive cycles; otherwise p0 has strict priority.
module rv32im_wb_arbiter
    import rv32im_wb_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
)(
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  p0_valid_i,
    output logic                  p0_ready_o,
    input  logic [REG_ADDR_W-1:0] p0_rd_i,
    input  logic [XLEN-1:0]       p0_data_i,
    input  logic                  p1_valid_i,
    output logic                  p1_ready_o,
    input  logic [REG_ADDR_W-1:0] p1_rd_i,
    input  logic [XLEN-1:0]       p1_data_i,
    input  logic                  issue_valid_i,
    input  logic [REG_ADDR_W-1:0] issue_rd_i,
    input  logic [REG_ADDR_W-1:0] rs1_addr_i,
    input  logic [REG_ADDR_W-1:0] rs2_addr_i,
    output logic                  rs1_busy_o,
    output logic                  rs2_busy_o,
    output logic                  we_o,
    output logic [REG_ADDR_W-1:0] rd_addr_o,
    output logic [XLEN-1:0]       val_rd_o
);

    if (STARVE_LIMIT == 0) begin : g_limit_check
        $error("STARVE_LIMIT must be at least 1");
    end

    logic p0_xfer;
    logic p1_xfer;

    assign p0_xfer = p0_valid_i & p0_ready_o;
    assign p1_xfer = p1_valid_i & p1_ready_o;

`ifdef RV32IM_WB_STARVE_EN
    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

    wb_state_e        state_q, state_d;
    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= PRI0;
            starve_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    // Entering FORCE1 on the edge where the count reaches the limit lets p1
    // win in the very next cycle (after exactly STARVE_LIMIT losses).
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!p1_valid_i || p1_xfer)
            starve_cnt_d = '0;
        else if (starve_cnt_q != CNT_W'(STARVE_LIMIT))
            starve_cnt_d = starve_cnt_q + 1'b1;

        state_d = state_q;
        case (state_q)
            PRI0:    if (starve_cnt_d == CNT_W'(STARVE_LIMIT)) state_d = FORCE1;
            FORCE1:  if (!p1_valid_i || p1_xfer)               state_d = PRI0;
            default: state_d = PRI0;
        endcase
    end

    always_comb begin
        p0_ready_o = 1'b1;
        p1_ready_o = !p0_valid_i;
        if (state_q == FORCE1) begin
            p1_ready_o = 1'b1;
            p0_ready_o = !p1_valid_i;
        end
    end
`else
    always_comb begin
        p0_ready_o = 1'b1;
        p1_ready_o = !p0_valid_i;
    end
`endif

    // Writes to x0 are accepted but never reach the register file.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            we_o      <= 1'b0;
            rd_addr_o <= '0;
            val_rd_o  <= '0;
        end else if (p0_xfer) begin
            we_o      <= (p0_rd_i != '0);
            rd_addr_o <= p0_rd_i;
            val_rd_o  <= p0_data_i;
        end else if (p1_xfer) begin
            we_o      <= (p1_rd_i != '0);
            rd_addr_o <= p1_rd_i;
            val_rd_o  <= p1_data_i;
        end else begin
            we_o      <= 1'b0;
        end
    end

    rv32im_wb_scoreboard u_scoreboard (
        .clk      (clk_i),
        .rst_n    (rst_n_i),
        .set_en   (issue_valid_i),
        .set_rd   (issue_rd_i),
        .clr_en   (p1_xfer),
        .clr_rd   (p1_rd_i),
        .rs1_addr (rs1_addr_i),
        .rs2_addr (rs2_addr_i),
        .rs1_busy (rs1_busy_o),
        .rs2_busy (rs2_busy_o)
    );

endmodule

// File: doc/rv32im_wb_arbiter.md
RV32IM_WB_ARBITER -- requirements
Module: rv32im_wb_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, which sets the number of consecutive cycles a pending p1 request may lose before it is force-granted.
REQ-002 SHALL have the ports below, one per line as name, direction, width, meaning:
- clk_i  in  1  sole clock; all state updates on the rising edge.
- rst_n_i  in  1  reset; asynchronous, active-low.
- p0_valid_i / p0_ready_o  in/out  1  handshake for the in-order pipeline writeback requester.
- p0_rd_i  in  5  destination register for p0.
- p0_data_i  in  32  write data for p0.
- p1_valid_i / p1_ready_o  in/out  1  handshake for the multi-cycle MUL/DIV result requester.
- p1_rd_i  in  5  destination register for p1.
- p1_data_i  in  32  write data for p1.
- issue_valid_i  in  1  a MUL/DIV op was issued this cycle.
- issue_rd_i  in  5  destination register of the issued MUL/DIV op.
- rs1_addr_i, rs2_addr_i  in  5  scoreboard lookup addresses.
- rs1_busy_o, rs2_busy_o  out  1  the looked-up register has a MUL/DIV write pending.
- we_o  out  1  register file write enable.
- rd_addr_o  out  5  register file write address.
- val_rd_o  out  32  register file write data.

Function
REQ-003 SHALL perform a transfer on port n in any cycle where pn_valid_i and pn_ready_o are both high; at most one transfer SHALL occur per cycle.
REQ-004 SHALL default to fixed priority: p0_ready_o=1; p1_ready_o=!p0_valid_i.
REQ-005 SHALL register its write outputs: a transfer in cycle N drives we_o, rd_addr_o and val_rd_o in cycle N+1; we_o=0 in any cycle not following a transfer.
REQ-006 SHALL treat rd=0 as a sink: a transfer with rd=0 is accepted, but we_o stays 0 for it.
REQ-007 SHALL keep a 32-bit busy scoreboard; bit 0 is hardwired to 0.
REQ-008 SHALL set busy[issue_rd_i] on a clock edge where issue_valid_i=1 and issue_rd_i!=0.
REQ-009 SHALL clear busy[p1_rd_i] on a p1 transfer.
REQ-010 SHALL let set win when a set and a clear of the same register coincide.
REQ-011 SHALL drive rsX_busy_o = busy[rsX_addr_i] combinationally, with no bypass of a same-cycle clear.
REQ-012 SHALL, when a p0 transfer and an issue target the same rd in one cycle, still set the bit; the p0 write is not suppressed.
REQ-013 SHALL leave the p1 write (p1 has no ordering check) and the resulting scoreboard bit as the issuing core's responsibility if p0 writes a register that is busy.

Reset
REQ-014 SHALL, while rst_n_i=0, asynchronously force: we_o=0, rd_addr_o=0, val_rd_o=0, all busy bits=0, starvation counter=0, FSM=PRI0.
REQ-015 SHALL drop any request in flight when reset asserts mid-operation; no write is issued on the first edge after deassert.

Configuration
REQ-016 SHALL compile anti-starvation logic in when macro RV32IM_WB_STARVE_EN is defined.
REQ-017 SHALL, with RV32IM_WB_STARVE_EN defined, run FSM states PRI0 and FORCE1:
- The counter increments each cycle p1_valid_i=1 and p1 gets no transfer, and resets to 0 on a p1 transfer or when p1_valid_i=0.
- PRI0 goes to FORCE1 when the counter reaches STARVE_LIMIT.
- In FORCE1: p1_ready_o=1, p0_ready_o=!p1_valid_i.
- FORCE1 returns to PRI0 after one p1 transfer, or immediately if p1_valid_i drops.
REQ-018 SHALL, without RV32IM_WB_STARVE_EN, have no counter and no FSM; strict p0 priority applies and p1 may starve indefinitely.

Structure
REQ-019 SHALL place in the shared rv32im package: REG_ADDR_W=5, XLEN=32, NUM_REGS=32, and the FSM state encoding (PRI0=0, FORCE1=1).
REQ-020 SHALL use one sub-module, rv32im_wb_scoreboard, holding the busy bits, set/clear and both lookup ports; arbitration and output registers stay in the top level.

Verification
REQ-021 SHALL cover: p0 only, rd=3, data=546 -> cycle+1: we_o=1, rd_addr_o=3, val_rd_o=546; p1_ready_o irrelevant.
REQ-022 SHALL cover: p0 valid, rd=0, data=654 -> p0_ready_o=1, we_o stays 0 next cycle.
REQ-023 SHALL cover: issue rd=5, then rs1_addr_i=5 -> rs1_busy_o=1; p1 transfer rd=5, data=12 -> busy clears on that edge, we_o=1 with 12 next cycle.
REQ-024 SHALL cover: issue rd=7 and p1 transfer rd=7 in the same cycle -> busy[7] remains 1.
REQ-025 SHALL cover, with STARVE_EN: p0 and p1 valid continuously -> p1 transfers on the 5th cycle (after 4 losses), p0_ready_o=0 that cycle, then PRI0 resumes; without the macro, p1 never transfers.
REQ-026 SHALL cover: rst_n_i asserted mid-stream with busy[9]=1 and we_o=1 -> all outputs 0 immediately, busy[9]=0, no write on the first edge after release.
